fpu_operand_loader: RTL and testbench
=====================================

// Module: fpu_operand_loader
// PURPOSE
//  Upstream feeder for the FPU core. Accepts IEEE-754 single-precision operand pairs over valid/ready.
//  Converts each operand to the FPU format: sign[31], exp[30:21] (bias 511), frac[20:0].
//  Drives Op_A_in/Op_B_in and holds them stable for HOLD_CYCLES so one full FPU
//  DECODE..WRITEBACK pass (worst case ~27 cycles) completes on constant operands.
// PARAMETERS
//  HOLD_CYCLES  32   cycles operands are held after accept; legal range 2..255
//  BIAS_IN      127  IEEE-754 exponent bias
//  BIAS_OUT     511  FPU exponent bias
// PORTS
//  clock_100Khz  in   1   system clock, rising edge
//  reset         in   1   asynchronous, active-low
//  in_valid      in   1   operand pair on ieee_a/ieee_b is valid
//  in_ready      out  1   loader can accept a pair
//  ieee_a        in   32  operand A, IEEE-754 single
//  ieee_b        in   32  operand B, IEEE-754 single
//  abort         in   1   synchronous: drop current hold, return to IDLE
//  op_a          out  32  converted A, connects to FPU Op_A_in
//  op_b          out  32  converted B, connects to FPU Op_B_in
//  op_valid      out  1   high while op_a/op_b are being held for the FPU
//  pass_done     out  1   one-cycle pulse on the last HOLD cycle
//  conv_inexact  out  2   [1]=A, [0]=B: conversion lost bits (rounding or denormal flush)
//  conv_special  out  2   [1]=A, [0]=B: input was zero/denormal/inf/NaN
// BEHAVIOUR
//  Reset values: state=IDLE, op_a=op_b=0, op_valid=0, pass_done=0, conv_inexact=conv_special=0, cnt=0.
//  in_ready = (state==IDLE) && !abort. It is combinational and reads 1 during reset; no accept can occur in reset.
//  FSM IDLE:
//    - in_valid && in_ready at an edge: register converted op_a/op_b and flags, op_valid<=1,
//      cnt<=HOLD_CYCLES-1, go to HOLD.
//    - Latency: converted operands are visible the cycle after the accept edge.
//  FSM HOLD:
//    - op_a/op_b/flags stay frozen; in_valid is ignored.
//    - cnt==0: at the next edge go to IDLE and op_valid<=0. pass_done is high during this cnt==0 cycle.
//    - Otherwise cnt<=cnt-1.
//    - The state occupies exactly HOLD_CYCLES cycles. Back-to-back accept period is HOLD_CYCLES+1.
//  op_a/op_b keep their last value after returning to IDLE. They change only on accept or reset.
//  abort takes priority over everything in HOLD: at the next edge go to IDLE, op_valid<=0, pass_done stays 0,
//    operands are retained. abort in IDLE blocks the accept in that cycle.
//  Async reset in any state returns all outputs to reset values immediately. An in-flight hold is lost.
//  Conversion, per operand (s,e[7:0],m[22:0]):
//   - e==0: output {s,31'd0}; special=1; inexact=(m!=0). Zero keeps its sign; denormals flush.
//   - e==255, m==0: output {s,10'd1023,21'd0}; special=1; inexact=0.
//   - e==255, m!=0: output {s,10'd1023,21'h1FFFFF} (canonical NaN); special=1; inexact=0.
//   - Otherwise, normal number:
//       - exp10 = e + (BIAS_OUT-BIAS_IN) = e+384, computed in 10 bits (range 385..638, no overflow).
//       - Rounding bits: lsb=m[2], guard=m[1], sticky=m[0]; round_up = guard & (sticky|lsb)
//         (round to nearest, ties to even).
//       - frac = m[22:2] + round_up. On a carry out of bit 20: frac=0, exp10=exp10+1.
//       - inexact = guard|sticky; special=0.
// STRUCTURE
//  fpu_pkg (shared with the FPU core):
//    - loader_state_t {IDLE,HOLD}
//    - localparams FPU_EXP_W=10, FPU_FRAC_W=21, FPU_BIAS=511, FPU_EXP_MAX=10'd1023
//    - fpu status_t enum, moved here from the FPU core
//  Sub-module ieee_to_fpu_conv: purely combinational single-operand converter (ieee in ->
//    fpu word, inexact, special). Instantiated twice. The top holds the FSM, counter and output registers.
// TESTING
//  1.0f=0x3F800000, 2.0f=0x40000000 -> op_a=0x3FE00000, op_b=0x40000000, inexact=00, special=00.
//  Rounding: 0x3F800003 -> 0x3FE00001, inexact=1; 0x3F800002 (tie, even) -> 0x3FE00000, inexact=1.
//  Carry: 0x3FFFFFFF -> 0x40000000, inexact=1. Negative: 0xBF800000 -> 0xBFE00000, exact.
//  Specials: 0x00000001 -> 0x00000000 (inexact=1, special=1); 0x80000000 -> 0x80000000 (special=1);
//    0x7F800000 -> 0x7FE00000; 0x7FC00000 -> 0x7FFFFFFF.
//  Handshake, HOLD_CYCLES=4, in_valid held high:
//    - accepts exactly every 5 cycles; op_valid high 4 cycles; pass_done one pulse per pass;
//    - operands change only at accept edges.
//  Abort and reset:
//    - abort in the 2nd HOLD cycle -> IDLE next edge, op_valid=0, no pass_done, op_a retained.
//    - reset low mid-HOLD -> all outputs 0 asynchronously.
//    - after release, the first accept behaves as in test 1.

Source files
------------

// File: rtl/fpu_pkg.sv
// ============================================================================
// Package : fpu_pkg
// Purpose : Types and constants shared between the FPU core and its operand
//           loader. Holds the loader state encoding, the FPU number-format
//           geometry and the FPU status enumeration.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_pkg;

   // FPU operand layout: sign[31], exp[30:21], frac[20:0]
   localparam int         FPU_EXP_W   = 10;
   localparam int         FPU_FRAC_W  = 21;
   localparam int         FPU_BIAS    = 511;
   localparam logic [9:0] FPU_EXP_MAX = 10'd1023;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } loader_state_t;

   // Status codes reported by the FPU core
   typedef enum logic [2:0] {
      ST_OK        = 3'd0,
      ST_INEXACT   = 3'd1,
      ST_OVERFLOW  = 3'd2,
      ST_UNDERFLOW = 3'd3,
      ST_INVALID   = 3'd4,
      ST_DIV_ZERO  = 3'd5
   } status_t;

endpackage : fpu_pkg

`default_nettype wire

// File: rtl/ieee_to_fpu_conv.sv
// ============================================================================
// Module  : ieee_to_fpu_conv
// Purpose : Purely combinational converter from one IEEE-754 single-precision
//           word to the FPU format (sign, 10-bit exp bias 511, 21-bit frac).
//           Rounds to nearest, ties to even; flushes denormals to signed zero;
//           maps infinities and NaNs to the FPU's max-exponent encodings.
// Ports   : ieee    in  32  IEEE-754 single operand
//           fpu     out 32  converted FPU operand
//           inexact out 1   conversion lost bits (rounding or denormal flush)
//           special out 1   input was zero/denormal/inf/NaN
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ieee_to_fpu_conv
   import fpu_pkg::*;
#(
   parameter int BIAS_IN  = 127,
   parameter int BIAS_OUT = 511
) (
   input  logic [31:0] ieee,
   output logic [31:0] fpu,
   output logic        inexact,
   output logic        special
);

   localparam logic [FPU_EXP_W-1:0] EXP_OFF = FPU_EXP_W'(BIAS_OUT - BIAS_IN);

   logic                  s;
   logic [7:0]            e;
   logic [22:0]           m;
   logic                  round_up;
   logic [FPU_FRAC_W:0]   frac_sum;   // one extra bit to catch the rounding carry
   logic [FPU_EXP_W-1:0]  exp_norm;
   logic [FPU_EXP_W-1:0]  exp_fin;

   assign s = ieee[31];
   assign e = ieee[30:23];
   assign m = ieee[22:0];

   // The two dropped mantissa bits act as guard (m[1]) and sticky (m[0]);
   // m[2] becomes the result lsb and breaks ties toward even.
   assign round_up = m[1] & (m[0] | m[2]);
   assign frac_sum = {1'b0, m[22:2]} + {{FPU_FRAC_W{1'b0}}, round_up};
   assign exp_norm = {2'b00, e} + EXP_OFF;
   // A carry out of the fraction leaves frac_sum[20:0] all zero, so only the
   // exponent needs bumping.
   assign exp_fin  = frac_sum[FPU_FRAC_W] ? exp_norm + 10'd1 : exp_norm;

   always_comb begin
      fpu     = 32'd0;
      inexact = 1'b0;
      special = 1'b0;
      if (e == 8'd0) begin
         fpu     = {s, 31'd0};
         special = 1'b1;
         inexact = (m != 23'd0);
      end else if (e == 8'hFF) begin
         special = 1'b1;
         if (m == 23'd0) begin
            fpu = {s, FPU_EXP_MAX, {FPU_FRAC_W{1'b0}}};
         end else begin
            fpu = {s, FPU_EXP_MAX, {FPU_FRAC_W{1'b1}}};
         end
      end else begin
         fpu     = {s, exp_fin, frac_sum[FPU_FRAC_W-1:0]};
         inexact = m[1] | m[0];
      end
   end

endmodule : ieee_to_fpu_conv

`default_nettype wire

// File: rtl/fpu_operand_loader.sv
// ============================================================================
// Module  : fpu_operand_loader
// Purpose : Accepts IEEE-754 operand pairs over valid/ready, converts them to
//           the FPU format and holds them stable for HOLD_CYCLES cycles so a
//           full FPU pass completes on constant operands.
// Ports   : clock_100Khz in  1   system clock, rising edge
//           reset        in  1   asynchronous, active-low
//           in_valid     in  1   operand pair valid
//           in_ready     out 1   loader can accept a pair
//           ieee_a/b     in  32  IEEE-754 single operands
//           abort        in  1   drop current hold, return to IDLE
//           op_a/b       out 32  converted operands to the FPU
//           op_valid     out 1   operands are being held
//           pass_done    out 1   pulse on the last hold cycle
//           conv_inexact out 2   [1]=A [0]=B conversion lost bits
//           conv_special out 2   [1]=A [0]=B zero/denormal/inf/NaN input
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_operand_loader
   import fpu_pkg::*;
#(
   parameter int HOLD_CYCLES = 32,
   parameter int BIAS_IN     = 127,
   parameter int BIAS_OUT    = 511
) (
   input  logic        clock_100Khz,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] ieee_a,
   input  logic [31:0] ieee_b,
   input  logic        abort,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   output logic        op_valid,
   output logic        pass_done,
   output logic [1:0]  conv_inexact,
   output logic [1:0]  conv_special
);

   localparam logic [7:0] CNT_LOAD = 8'(HOLD_CYCLES - 1);

   loader_state_t state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [31:0]   op_a_q, op_a_d;
   logic [31:0]   op_b_q, op_b_d;
   logic          op_valid_q, op_valid_d;
   logic [1:0]    inexact_q, inexact_d;
   logic [1:0]    special_q, special_d;

   logic [31:0]   conv_a, conv_b;
   logic          inx_a, inx_b, spc_a, spc_b;

   ieee_to_fpu_conv #(
      .BIAS_IN  (BIAS_IN),
      .BIAS_OUT (BIAS_OUT)
   ) u_conv_a (
      .ieee    (ieee_a),
      .fpu     (conv_a),
      .inexact (inx_a),
      .special (spc_a)
   );

   ieee_to_fpu_conv #(
      .BIAS_IN  (BIAS_IN),
      .BIAS_OUT (BIAS_OUT)
   ) u_conv_b (
      .ieee    (ieee_b),
      .fpu     (conv_b),
      .inexact (inx_b),
      .special (spc_b)
   );

   always_ff @(posedge clock_100Khz or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= 8'd0;
         op_a_q     <= 32'd0;
         op_b_q     <= 32'd0;
         op_valid_q <= 1'b0;
         inexact_q  <= 2'b00;
         special_q  <= 2'b00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         op_valid_q <= op_valid_d;
         inexact_q  <= inexact_d;
         special_q  <= special_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      op_valid_d = op_valid_q;
      inexact_d  = inexact_q;
      special_d  = special_q;
      case (state_q)
         IDLE: begin
            if (in_valid && !abort) begin
               op_a_d     = conv_a;
               op_b_d     = conv_b;
               inexact_d  = {inx_a, inx_b};
               special_d  = {spc_a, spc_b};
               op_valid_d = 1'b1;
               cnt_d      = CNT_LOAD;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            if (abort || (cnt_q == 8'd0)) begin
               op_valid_d = 1'b0;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            op_valid_d = 1'b0;
            state_d    = IDLE;
         end
      endcase
   end

   assign in_ready     = (state_q == IDLE) && !abort;
   // Gated by abort so an aborted final cycle never reports a completed pass.
   assign pass_done    = (state_q == HOLD) && (cnt_q == 8'd0) && !abort;
   assign op_a         = op_a_q;
   assign op_b         = op_b_q;
   assign op_valid     = op_valid_q;
   assign conv_inexact = inexact_q;
   assign conv_special = special_q;

endmodule : fpu_operand_loader

`default_nettype wire

// File: tb/tb_fpu_operand_loader.sv
`default_nettype none

module tb_fpu_operand_loader;

   localparam int HOLD = 4;

   logic        clock_100Khz = 1'b0;
   logic        reset        = 1'b0;
   logic        in_valid     = 1'b0;
   logic        in_ready;
   logic [31:0] ieee_a       = 32'd0;
   logic [31:0] ieee_b       = 32'd0;
   logic        abort        = 1'b0;
   logic [31:0] op_a, op_b;
   logic        op_valid, pass_done;
   logic [1:0]  conv_inexact, conv_special;

   int n_checks = 0;
   int n_errors = 0;

   fpu_operand_loader #(.HOLD_CYCLES(HOLD)) dut (
      .clock_100Khz (clock_100Khz),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .ieee_a       (ieee_a),
      .ieee_b       (ieee_b),
      .abort        (abort),
      .op_a         (op_a),
      .op_b         (op_b),
      .op_valid     (op_valid),
      .pass_done    (pass_done),
      .conv_inexact (conv_inexact),
      .conv_special (conv_special)
   );

   always #5 clock_100Khz = ~clock_100Khz;

   task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // One accept followed by a full hold; checks operands, flags and the
   // op_valid / pass_done timeline, then the return to IDLE.
   task automatic run_pass(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ea, input logic [31:0] eb,
                           input logic [1:0] ei, input logic [1:0] es);
      @(negedge clock_100Khz);
      check_value("ready_before", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; ieee_a = a; ieee_b = b;
      @(posedge clock_100Khz); #1;
      in_valid = 1'b0; ieee_a = $urandom; ieee_b = $urandom;
      for (int i = 0; i < HOLD; i++) begin
         @(negedge clock_100Khz);
         check_value("hold_op_a", op_a, ea);
         check_value("hold_op_b", op_b, eb);
         check_value("hold_valid", {31'd0, op_valid}, 32'd1);
         check_value("hold_pass_done", {31'd0, pass_done}, (i == HOLD - 1) ? 32'd1 : 32'd0);
         if (i == 0) begin
            check_value("inexact", {30'd0, conv_inexact}, {30'd0, ei});
            check_value("special", {30'd0, conv_special}, {30'd0, es});
         end
      end
      @(negedge clock_100Khz);
      check_value("idle_valid", {31'd0, op_valid}, 32'd0);
      check_value("idle_pass_done", {31'd0, pass_done}, 32'd0);
      check_value("idle_ready", {31'd0, in_ready}, 32'd1);
      check_value("idle_op_a_kept", op_a, ea);
   endtask

   task automatic check_all_zero(input string tag);
      check_value({tag, "_op_a"}, op_a, 32'd0);
      check_value({tag, "_op_b"}, op_b, 32'd0);
      check_value({tag, "_valid"}, {31'd0, op_valid}, 32'd0);
      check_value({tag, "_pass_done"}, {31'd0, pass_done}, 32'd0);
      check_value({tag, "_flags"}, {28'd0, conv_inexact, conv_special}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_a;
      int          acc_base;

      // Reset state
      #12;
      check_all_zero("reset");
      check_value("reset_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clock_100Khz); reset = 1'b1;

      // Conversion vectors
      run_pass(32'h3F800000, 32'h40000000, 32'h3FE00000, 32'h40000000, 2'b00, 2'b00);
      run_pass(32'h3F800003, 32'h3F800002, 32'h3FE00001, 32'h3FE00000, 2'b11, 2'b00);
      run_pass(32'h3FFFFFFF, 32'hBF800000, 32'h40000000, 32'hBFE00000, 2'b10, 2'b00);
      run_pass(32'h00000001, 32'h80000000, 32'h00000000, 32'h80000000, 2'b10, 2'b11);
      run_pass(32'h7F800000, 32'h7FC00000, 32'h7FE00000, 32'h7FFFFFFF, 2'b00, 2'b11);

      // Back-to-back with in_valid held high; ieee_a carries the cycle index
      // in its fraction so the captured value identifies the accept cycle.
      @(negedge clock_100Khz);
      for (int j = 0; j <= 15; j++) begin
         if (j > 0) begin
            acc_base = 5 * ((j - 1) / 5);
            exp_a    = 32'h3FE00000 + 32'(acc_base);
            check_value("b2b_op_a", op_a, exp_a);
            check_value("b2b_valid", {31'd0, op_valid}, ((j - 1) % 5 < 4) ? 32'd1 : 32'd0);
            check_value("b2b_pass_done", {31'd0, pass_done}, ((j - 1) % 5 == 3) ? 32'd1 : 32'd0);
         end
         in_valid = 1'b1;
         ieee_a   = 32'h3F800000 | (32'(j) << 2);
         ieee_b   = 32'h40000000;
         @(negedge clock_100Khz);
      end
      in_valid = 1'b0;
      repeat (HOLD + 1) @(negedge clock_100Khz);

      // Abort in the second hold cycle
      in_valid = 1'b1; ieee_a = 32'h40000000; ieee_b = 32'h3F800000;
      @(posedge clock_100Khz); #1; in_valid = 1'b0;
      @(negedge clock_100Khz);
      @(negedge clock_100Khz);
      abort = 1'b1;
      #1;
      check_value("abort_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clock_100Khz); #1; abort = 1'b0;
      @(negedge clock_100Khz);
      check_value("abort_valid", {31'd0, op_valid}, 32'd0);
      check_value("abort_pass_done", {31'd0, pass_done}, 32'd0);
      check_value("abort_op_a_kept", op_a, 32'h40000000);
      check_value("abort_op_b_kept", op_b, 32'h3FE00000);

      // Abort on the last hold cycle suppresses pass_done
      in_valid = 1'b1; ieee_a = 32'h3F800000;
      @(posedge clock_100Khz); #1; in_valid = 1'b0;
      repeat (HOLD) @(negedge clock_100Khz);
      check_value("last_pass_done", {31'd0, pass_done}, 32'd1);
      abort = 1'b1; #1;
      check_value("last_abort_pass_done", {31'd0, pass_done}, 32'd0);
      @(posedge clock_100Khz); #1; abort = 1'b0;

      // Abort in IDLE blocks the accept
      @(negedge clock_100Khz);
      abort = 1'b1; in_valid = 1'b1; ieee_a = 32'h40000000;
      #1;
      check_value("idle_abort_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clock_100Khz); #1; in_valid = 1'b0; abort = 1'b0;
      @(negedge clock_100Khz);
      check_value("idle_abort_no_accept", {31'd0, op_valid}, 32'd0);
      check_value("idle_abort_op_a", op_a, 32'h3FE00000);

      // Asynchronous reset mid-hold
      in_valid = 1'b1; ieee_a = 32'h3FFFFFFF; ieee_b = 32'h00000001;
      @(posedge clock_100Khz); #1; in_valid = 1'b0;
      @(negedge clock_100Khz);
      @(negedge clock_100Khz);
      #2 reset = 1'b0;
      #1;
      check_all_zero("async_reset");
      repeat (2) @(negedge clock_100Khz);
      reset = 1'b1;

      // First accept after reset release
      run_pass(32'h3F800000, 32'h40000000, 32'h3FE00000, 32'h40000000, 2'b00, 2'b00);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_fpu_operand_loader

`default_nettype wire
